// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers.
// No logic: state encoding and payload-width constants only.
// Used by every pipe_* stage module.
package pipe_pkg;

  // Stage occupancy: EMPTY (nothing held), FULL (main only), SKID (main + skid). 2'd3 is illegal.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_t;

  localparam logic [31:0] NOP_WORD = 32'h0;
  localparam int          PC_W     = 7;
  localparam int          INSTR_W  = 32;
  localparam int          IF_ID_W  = PC_W + INSTR_W;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Latency: count updates on the edge after inc/clr; clear wins over increment.
// Backpressure: none, pure sink of events; holds at all-ones instead of wrapping.
module pipe_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  // Count events, stick at the maximum, clear on request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, 2-entry skid, flush and bubble tagging.
// Latency: 1 cycle from acceptance to out_*; full throughput while downstream is ready.
// Backpressure: in_ready comes straight from state (no comb path from out_ready); drops only in SKID.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W      = IF_ID_W,
  parameter bit BUBBLE_ZERO = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_bubble,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_bubble,
  input  logic              clr_stats,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_state_t       state_q, state_d;
  logic [DATA_W-1:0] main_dat_q, main_dat_d;
  logic [DATA_W-1:0] skid_dat_q, skid_dat_d;
  logic              main_bub_q, main_bub_d;
  logic              skid_bub_q, skid_bub_d;
  logic [DATA_W-1:0] in_store_dat;
  logic              acc;
  logic              pop;

  // The illegal encoding 2'd3 reads as EMPTY: not valid, ready to accept.
  assign in_ready   = (state_q != SKID);
  assign out_valid  = (state_q == FULL) || (state_q == SKID);
  assign out_data   = main_dat_q;
  assign out_bubble = main_bub_q;

  assign acc = in_valid & in_ready;
  assign pop = out_valid & out_ready;

  // Bubbles may be stored as a zero payload so downstream sees a clean NOP word.
  assign in_store_dat = (BUBBLE_ZERO && in_bubble) ? '0 : in_data;

  // Next state and register contents; flush overrides every handshake.
  always_comb begin
    state_d    = state_q;
    main_dat_d = main_dat_q;
    main_bub_d = main_bub_q;
    skid_dat_d = skid_dat_q;
    skid_bub_d = skid_bub_q;
    if (flush) begin
      state_d    = EMPTY;
      main_dat_d = '0;
      main_bub_d = 1'b0;
      skid_dat_d = '0;
      skid_bub_d = 1'b0;
    end else begin
      case (state_q)
        FULL: begin
          if (acc && pop) begin
            main_dat_d = in_store_dat;
            main_bub_d = in_bubble;
          end else if (acc) begin
            skid_dat_d = in_store_dat;
            skid_bub_d = in_bubble;
            state_d    = SKID;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        SKID: begin
          if (pop) begin
            main_dat_d = skid_dat_q;
            main_bub_d = skid_bub_q;
            state_d    = FULL;
          end
        end
        default: begin
          if (acc) begin
            main_dat_d = in_store_dat;
            main_bub_d = in_bubble;
            state_d    = FULL;
          end
        end
      endcase
    end
  end

  // State, main and skid registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= EMPTY;
      main_dat_q <= '0;
      main_bub_q <= 1'b0;
      skid_dat_q <= '0;
      skid_bub_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_dat_q <= main_dat_d;
      main_bub_q <= main_bub_d;
      skid_dat_q <= skid_dat_d;
      skid_bub_q <= skid_bub_d;
    end
  end

  pipe_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_valid & ~out_ready),
    .clr   (clr_stats),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: two instances (zeroing bubbles / 4-bit counter, and raw bubbles / 16-bit counter).
// Stimulus issued once per cycle just after the rising edge; checks on the falling edge.
// Scoreboard queues are filled by a depth-2 FIFO model and drained by the output monitor.
module tb_pipe_stage_reg;

  localparam int DW = 39;

  typedef struct {
    logic [DW-1:0] dat;
    logic          bub;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush, in_valid, in_bubble, out_ready, clr_stats;
  logic [DW-1:0] in_data;

  logic          in_ready0, out_valid0, out_bubble0;
  logic [DW-1:0] out_data0;
  logic [3:0]    stall0;
  logic          in_ready1, out_valid1, out_bubble1;
  logic [DW-1:0] out_data1;
  logic [15:0]   stall1;

  int   n_assert = 0;
  int   n_fail   = 0;
  int   occ      = 0;
  int   cnt0     = 0;
  int   cnt1     = 0;
  ent_t q0[$];
  ent_t q1[$];

  pipe_stage_reg #(.DATA_W(DW), .BUBBLE_ZERO(1'b1), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_bubble(in_bubble),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_bubble(out_bubble0),
    .clr_stats(clr_stats), .stall_cnt(stall0)
  );

  pipe_stage_reg #(.DATA_W(DW), .BUBBLE_ZERO(1'b0), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_bubble(in_bubble),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_bubble(out_bubble1),
    .clr_stats(clr_stats), .stall_cnt(stall1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the stage is a 2-deep FIFO whose ready is "not full" at the start of the cycle.
  always @(posedge clk or negedge rst) begin
    bit acc, pop, stall;
    if (!rst) begin
      occ = 0; cnt0 = 0; cnt1 = 0;
      q0.delete(); q1.delete();
    end else begin
      acc   = in_valid && (occ < 2);
      pop   = (occ > 0) && out_ready;
      stall = (occ > 0) && !out_ready;
      if (clr_stats) begin
        cnt0 = 0; cnt1 = 0;
      end else if (stall) begin
        if (cnt0 < 15)    cnt0++;
        if (cnt1 < 65535) cnt1++;
      end
      if (flush) begin
        occ = 0;
        q0.delete(); q1.delete();
      end else begin
        occ = occ - (pop ? 1 : 0) + (acc ? 1 : 0);
        if (acc) begin
          q0.push_back('{dat: (in_bubble ? '0 : in_data), bub: in_bubble});
          q1.push_back('{dat: in_data, bub: in_bubble});
        end
      end
    end
  end

  // Monitor: compare flags and counters every cycle, compare the head against the scoreboard, pop on handshake.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_out_valid0", out_valid0, 0);
      chk("rst_in_ready0", in_ready0, 1);
      chk("rst_stall0", stall0, 0);
      chk("rst_out_data0", out_data0, 0);
      chk("rst_out_bubble0", out_bubble0, 0);
      chk("rst_out_valid1", out_valid1, 0);
      chk("rst_in_ready1", in_ready1, 1);
      chk("rst_stall1", stall1, 0);
    end else begin
      chk("out_valid0", out_valid0, occ > 0);
      chk("in_ready0", in_ready0, occ < 2);
      chk("stall0", stall0, cnt0);
      chk("out_valid1", out_valid1, occ > 0);
      chk("in_ready1", in_ready1, occ < 2);
      chk("stall1", stall1, cnt1);
      if (out_valid0) begin
        n_assert++;
        if (q0.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_out0: out_valid=1 data=%0h with no pending entry", out_data0);
        end else begin
          chk("out_data0", out_data0, q0[0].dat);
          chk("out_bubble0", out_bubble0, q0[0].bub);
          if (out_ready) void'(q0.pop_front());
        end
      end
      if (out_valid1) begin
        n_assert++;
        if (q1.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_out1: out_valid=1 data=%0h with no pending entry", out_data1);
        end else begin
          chk("out_data1", out_data1, q1[0].dat);
          chk("out_bubble1", out_bubble1, q1[0].bub);
          if (out_ready) void'(q1.pop_front());
        end
      end
    end
  end

  task automatic step(input logic v, input logic [DW-1:0] d, input logic b,
                      input logic ordy, input logic fl, input logic cl);
    in_valid  = v;
    in_data   = d;
    in_bubble = b;
    out_ready = ordy;
    flush     = fl;
    clr_stats = cl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] r;
    rst = 1'b0;
    in_valid = 1'b0; in_data = '0; in_bubble = 1'b0;
    out_ready = 1'b0; flush = 1'b0; clr_stats = 1'b0;

    // Reset held for 3 cycles with in_valid asserted.
    repeat (3) step(1'b1, 39'h5, 1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;

    // Back-to-back streaming.
    for (int i = 1; i <= 16; i++) step(1'b1, DW'(i), 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Backpressure into SKID, then release.
    step(1'b1, 39'h0AA, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 39'h0BB, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Flush while in SKID with a new entry offered.
    step(1'b1, 39'h0DD, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 39'h0EE, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 39'h0CC, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Bubble with a non-zero payload, held one cycle then drained.
    step(1'b1, 39'h7F_DEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Long stall to saturate the narrow counter, clear mid-stall, resume.
    step(1'b1, 39'h123, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (20) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Random traffic with an asynchronous reset in the middle.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        rst = 1'b0;
        repeat (2) step(1'b1, 39'h1, 1'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
      end
      r = {$urandom(), $urandom()};
      step($urandom_range(3, 0) != 0, r[DW-1:0], $urandom_range(3, 0) == 0,
           $urandom_range(9, 0) < 6, $urandom_range(19, 0) == 0, $urandom_range(29, 0) == 0);
    end

    // Drain and confirm every accepted entry came out.
    repeat (4) step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
